// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU datapath and a word-only data memory.
// Sub-word stores become read-modify-write; misaligned or out-of-range accesses complete with err.
module mem_access_unit #(
  parameter int unsigned ADDR_LIMIT = 128
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req,
  output logic        ready,
  input  logic        st,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] addr_q, wdata_q, rbuf_q;
  logic [1:0]  size_q;
  logic        st_q, uns_q;

  logic        req_err;
  logic        accept;
  logic [31:0] merged;

  // Selects the addressed lane of a little-endian word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  ofs,
                                              input logic        zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{ofs, 3'b000} +: 8];
    h = ofs[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r = zext ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replaces the addressed lane of the old word with the right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  ofs);
    logic [31:0] r;
    r = word;
    case (sz)
      SZ_BYTE: r[{ofs, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: begin
        if (ofs[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    req_err = (size == SZ_BAD)
            | ((size == SZ_HALF) && addr[0])
            | ((size == SZ_WORD) && (addr[1:0] != 2'b00))
            | (addr >= ADDR_LIMIT);
  end

  assign accept = (state_q == IDLE) && req;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          err_d   = req_err;
          state_d = req_err ? DONE : READ;
        end
      end
      READ: begin
        if (st_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = load_extend(mem_rdata, size_q, addr_q[1:0], uns_q);
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Resetn) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: request and read-buffer registers carry no reset; they are always written before being used.
  always_ff @(posedge Clock) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      st_q    <= st;
      size_q  <= size;
      uns_q   <= uns;
    end
    if (state_q == READ) begin
      rbuf_q <= mem_rdata;
    end
  end

  assign merged = store_merge(rbuf_q, wdata_q, size_q, addr_q[1:0]);

  // Handshake outputs are gated by Resetn so a reset mid-write suppresses the write that cycle.
  assign ready     = Resetn && (state_q == IDLE);
  assign mem_we    = Resetn && (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign err       = done && err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = merged;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store/error vectors against a
// 32-word memory model (word[i]=i*i), plus hand sequences for busy-request and reset-in-WRITE.
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        req, st, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.ADDR_LIMIT(128)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .req       (req),
    .ready     (ready),
    .st        (st),
    .size      (size),
    .uns       (uns),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we)
  );

  always #5 Clock = ~Clock;

  assign mem_rdata = mem[mem_addr[6:2]];
  always @(posedge Clock) if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic e, input logic [31:0] rd, input int lat,
                              input int we, input logic [31:0] ewd);
    vec_t v;
    v.st = s; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_err = e; v.exp_rdata = rd; v.exp_lat = lat; v.exp_we = we; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Results of the most recent run_op.
  logic        got_err;
  logic [31:0] got_rdata, got_wdata, got_waddr;
  int          got_lat, got_we;

  task automatic run_op(input string tag, input vec_t v);
    int guard;
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    check({tag, "_ready"}, {31'h0, ready}, 32'h1);
    req = 1'b1; st = v.st; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
    @(negedge Clock);
    req = 1'b0;
    got_lat = 1; got_we = 0; got_wdata = 32'h0; got_waddr = 32'h0;
    while (!done && got_lat < 10) begin
      if (mem_we) begin
        got_we++;
        got_wdata = mem_wdata;
        got_waddr = mem_addr;
      end
      @(negedge Clock);
      got_lat++;
    end
    if (mem_we) got_we++;
    check({tag, "_done_seen"}, {31'h0, done}, 32'h1);
    got_err   = err;
    got_rdata = rdata;
    check({tag, "_err"},   {31'h0, got_err}, {31'h0, v.exp_err});
    check({tag, "_rdata"}, got_rdata, v.exp_rdata);
    check({tag, "_lat"},   got_lat, v.exp_lat);
    check({tag, "_we_cnt"}, got_we, v.exp_we);
    if (v.exp_we > 0) begin
      check({tag, "_wdata"}, got_wdata, v.exp_wdata);
      check({tag, "_waddr"}, got_waddr, {v.addr[31:2], 2'b00});
    end
    @(negedge Clock);
    check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    int cnt_we, cnt_done;
    for (int i = 0; i < 32; i++) mem[i] = i * i;
    Resetn = 1'b0; req = 1'b0; st = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0;

    // st, size, uns, addr, wdata, err, rdata, latency, we count, merged word
    vecs.push_back(mk(0, 2'b00, 1, 32'h7D, 32'h0,        0, 32'h00000003, 2, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h3C, 32'h0,        0, 32'hFFFFFFE1, 2, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h3C, 32'h0,        0, 32'h000000E1, 2, 0, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h15, 32'h000000AB, 0, 32'h000000E1, 3, 1, 32'h0000AB19));
    vecs.push_back(mk(0, 2'b10, 0, 32'h14, 32'h0,        0, 32'h0000AB19, 2, 0, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0E, 32'hDEAD1234, 0, 32'h0000AB19, 3, 1, 32'h12340009));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0E, 32'h0,        0, 32'h00001234, 2, 0, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h20, 32'h8001FFFF, 0, 32'h00001234, 3, 1, 32'h8001FFFF));
    vecs.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0,        0, 32'hFFFF8001, 2, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h22, 32'h0,        0, 32'h00008001, 2, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h20, 32'h0,        0, 32'hFFFFFFFF, 2, 0, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h27, 32'h000000CD, 0, 32'hFFFFFFFF, 3, 1, 32'hCD000051));
    vecs.push_back(mk(0, 2'b00, 1, 32'h7F, 32'h0,        0, 32'h00000000, 2, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h27, 32'h0,        0, 32'hFFFFFFCD, 2, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h03, 32'h0,        1, 32'hFFFFFFCD, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h80, 32'h0,        1, 32'hFFFFFFCD, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h00, 32'h0,        1, 32'hFFFFFFCD, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h80, 32'h12345678, 1, 32'hFFFFFFCD, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h01, 32'h5555,     1, 32'hFFFFFFCD, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h02, 32'h0,        1, 32'hFFFFFFCD, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'hFFFFFFFC, 32'h0,  1, 32'hFFFFFFCD, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h7C, 32'h0,        0, 32'h000003C1, 2, 0, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h24, 32'h0,        0, 32'hCD000051, 2, 0, 32'h0));

    // Reset state
    repeat (3) @(negedge Clock);
    check("rst_ready",  {31'h0, ready},  32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_done",   {31'h0, done},   32'h0);
    check("rst_err",    {31'h0, err},    32'h0);
    check("rst_rdata",  rdata,           32'h0);
    Resetn = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < vecs.size(); i++) run_op($sformatf("v%0d", i), vecs[i]);
    check("mem5_final", mem[5], 32'h0000AB19);
    check("mem0_untouched", mem[0], 32'h0);

    // Request raised while busy must be dropped, not queued
    req = 1'b1; st = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h7C; wdata = 32'h0;
    @(negedge Clock);
    st = 1'b1; addr = 32'h00; wdata = 32'hBAD0BAD0;
    check("busy_ready_read", {31'h0, ready}, 32'h0);
    @(negedge Clock);
    check("busy_done", {31'h0, done}, 32'h1);
    check("busy_rdata", rdata, 32'h000003C1);
    req = 1'b0;
    cnt_we = 0; cnt_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      if (mem_we) cnt_we++;
      if (done) cnt_done++;
    end
    check("busy_no_we",   cnt_we,   0);
    check("busy_no_done", cnt_done, 0);
    check("busy_idle",    {31'h0, ready}, 32'h1);
    check("busy_mem0",    mem[0], 32'h0);

    // Reset asserted while in WRITE aborts the store
    req = 1'b1; st = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h40; wdata = 32'h77;
    @(negedge Clock);
    req = 1'b0;
    @(negedge Clock);
    check("rw_we_before", {31'h0, mem_we}, 32'h1);
    Resetn = 1'b0;
    #1;
    check("rw_we_in_rst",    {31'h0, mem_we}, 32'h0);
    check("rw_ready_in_rst", {31'h0, ready},  32'h0);
    @(negedge Clock);
    check("rw_done_after", {31'h0, done}, 32'h0);
    check("rw_rdata_rst",  rdata, 32'h0);
    Resetn = 1'b1;
    @(negedge Clock);
    check("rw_ready_rel", {31'h0, ready}, 32'h1);
    check("rw_no_done",   {31'h0, done},  32'h0);
    check("rw_mem16",     mem[16], 32'h00000100);
    run_op("rw_load", mk(0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h00000100, 2, 0, 32'h0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the single-cycle CPU datapath and the 32-word data memory.
- Accepts byte, halfword and word loads and stores. Performs sign or zero extension on loads.
- Implements sub-word stores as read-modify-write on the word-only memory port.
- Flags misaligned and out-of-range accesses. A flagged access is completed with an error and never touches memory.

Parameters:
- ADDR_LIMIT, 128: byte-address bound; any addr >= ADDR_LIMIT is an error (32 words x 4 bytes).

Ports:
- Clock  in  1  sole clock; rising edge.
- Resetn  in  1  synchronous, active-low reset.
- req  in  1  access request; sampled only when ready=1.
- ready  out  1  unit idle and accepting requests.
- st  in  1  1=store, 0=load.
- size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- uns  in  1  load zero-extend (1) or sign-extend (0); ignored for word and store.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  extended load result; valid while done=1; holds until next load completes.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = access rejected.
- mem_addr  out  32  word address to memory, {addr_q[31:2],2'b00}.
- mem_wdata  out  32  merged word to memory.
- mem_rdata  in  32  asynchronous read data from memory.
- mem_we  out  1  memory write enable, sampled on Clock rising edge.

Behaviour:
- Reset (Resetn=0 at a rising edge):
  - state<=IDLE; rdata<=0; done<=0; err<=0.
  - While Resetn=0: ready=0 and mem_we=0 combinationally.
  - Reset mid-operation aborts the access with no write and no done.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - ready=1.
  - On req=1: latch addr_q, wdata_q, st_q, size_q, uns_q.
  - Error checks: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr>=ADDR_LIMIT.
  - Any error -> DONE with err_q=1. Otherwise -> READ.
- READ:
  - mem_we=0; mem_addr driven; mem_rdata captured into rbuf.
  - Load: compute result from byte lane addr_q[1:0] or half lane addr_q[1], extended per uns_q; -> DONE.
  - Store: merged = rbuf with the selected lane replaced by wdata_q[7:0] / [15:0]; word store uses wdata_q directly; -> WRITE.
- WRITE: mem_we=1 and mem_wdata=merged for exactly this cycle; -> DONE.
- DONE:
  - done=1, err=err_q; rdata updated only for a successful load; -> IDLE.
  - ready=0 in this cycle; the next request is accepted in the following cycle.
- Latency from accept edge to done cycle:
  - load: 2 cycles;
  - store: 3 cycles;
  - error: 1 cycle.
- Lanes are little-endian: byte k = bits [8k+7:8k].
- req while ready=0 is ignored (not queued).
- mem_we is never asserted outside WRITE.
- An errored access never asserts mem_we.

Test Plan:
- Memory preset word[i]=i*i. Load byte uns=1 addr=0x7D (word31=0x3C1) -> done after 2 cycles, rdata=0x00000003, err=0, no mem_we.
- Load byte addr=0x3C (word15=0xE1): uns=0 -> rdata=0xFFFFFFE1; uns=1 -> rdata=0x000000E1.
- Store byte wdata=0xAB addr=0x15 (word5=0x19):
  - exactly one mem_we cycle with mem_wdata=0x0000AB19 at mem_addr=0x14;
  - subsequent word load at 0x14 returns 0x0000AB19.
- Store half wdata=0x1234 addr=0x0E (word3=9) -> mem_wdata=0x12340009. Then load half uns=0 at 0x0E -> rdata=0x00001234.
- Error cases, each done 1 cycle after accept with err=1, no mem_we, rdata unchanged:
  - half at addr=0x03;
  - word at addr=0x80;
  - size=11.
- Store byte, Resetn=0 asserted while in WRITE -> mem_we=0 that cycle, memory word unchanged, no done, ready=1 the cycle after reset releases.
